// File: rtl/sadd_rr_arbiter_if.sv
// Bundle between the four requesters and the serial-adder arbiter.
// Optional signed-overflow flag is present when SADD_ARB_OVF_EN is defined.
interface sadd_rr_arbiter_if #(
    parameter int unsigned W = 8
);
    logic [3:0]     req;
    logic [4*W-1:0] op_a;
    logic [4*W-1:0] op_b;
    logic [3:0]     gnt;
    logic           busy;
    logic [W-1:0]   sum;
    logic           cout;
    logic [3:0]     done;
`ifdef SADD_ARB_OVF_EN
    logic           ovf;

    modport master (
        output req, op_a, op_b,
        input  gnt, busy, sum, cout, done, ovf
    );
    modport slave (
        input  req, op_a, op_b,
        output gnt, busy, sum, cout, done, ovf
    );
`else
    modport master (
        output req, op_a, op_b,
        input  gnt, busy, sum, cout, done
    );
    modport slave (
        input  req, op_a, op_b,
        output gnt, busy, sum, cout, done
    );
`endif
endinterface

// File: rtl/sadd_rr_arbiter.sv
// Round-robin arbiter time-sharing one bit-serial full adder among 4 requesters.
// Define SADD_ARB_OVF_EN to add the registered two's-complement overflow flag.
module sadd_rr_arbiter #(
    parameter int unsigned W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    sadd_rr_arbiter_if.slave  bus
);

    localparam int unsigned N  = 4;
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [1:0]      ptr_q;
    logic [1:0]      win_q;
    logic [CW-1:0]   cnt_q;
    logic            carry_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    res_q;
    logic [N-1:0]    gnt_q;
    logic            busy_q;
    logic [W-1:0]    sum_q;
    logic            cout_q;
    logic [N-1:0]    done_q;
`ifdef SADD_ARB_OVF_EN
    logic            ovf_q;
`endif

    logic [1:0]      win_c;
    logic            found_c;
    logic [1:0]      idx_c;
    logic [W-1:0]    opa_c;
    logic [W-1:0]    opb_c;
    logic            s_c;
    logic            c_c;
    logic [W-1:0]    res_d;

    // Rotating priority search: descending scan so the lowest offset from ptr wins.
    always_comb begin
        win_c   = ptr_q;
        found_c = 1'b0;
        idx_c   = '0;
        for (int k = 3; k >= 0; k--) begin
            idx_c = ptr_q + 2'(k);
            if (bus.req[idx_c]) begin
                win_c   = idx_c;
                found_c = 1'b1;
            end
        end
    end

    // Operand slice of the current winner.
    always_comb begin
        opa_c = '0;
        opb_c = '0;
        for (int i = 0; i < 4; i++) begin
            if (win_c == 2'(i)) begin
                opa_c = bus.op_a[i*W +: W];
                opb_c = bus.op_b[i*W +: W];
            end
        end
    end

    // Shared 1-bit full adder and the result register's next value.
    always_comb begin
        s_c   = a_q[0] ^ b_q[0] ^ carry_q;
        c_c   = (a_q[0] & b_q[0]) | (b_q[0] & carry_q) | (carry_q & a_q[0]);
        res_d = {s_c, res_q[W-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= '0;
`ifdef SADD_ARB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= '0;
            case (state_q)
                IDLE: begin
                    if (found_c) begin
                        gnt_q   <= N'(1) << win_c;
                        busy_q  <= 1'b1;
                        win_q   <= win_c;
                        a_q     <= opa_c;
                        b_q     <= opb_c;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    carry_q <= c_c;
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    res_q   <= res_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) begin
                        // carry_q here is the carry into the MSB.
                        sum_q   <= res_d;
                        cout_q  <= c_c;
`ifdef SADD_ARB_OVF_EN
                        ovf_q   <= carry_q ^ c_c;
`endif
                        done_q  <= gnt_q;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    ptr_q   <= win_q + 2'd1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.busy = busy_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.done = done_q;
`ifdef SADD_ARB_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_sadd_rr_arbiter.sv
// Self-checking bench for sadd_rr_arbiter: vector table plus multi-cycle corner sequences.
module tb_sadd_rr_arbiter;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sadd_rr_arbiter_if #(.W(W)) bus();

    sadd_rr_arbiter #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int           idx;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs [6];
    vec_t sbq  [$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   lat;
    int   t_prev;
    int   t_now;
    logic any_done;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        vec_t    v;
        logic [W:0] s;
        s      = {1'b0, a} + {1'b0, b};
        v.idx  = idx;
        v.a    = a;
        v.b    = b;
        v.sum  = s[W-1:0];
        v.cout = s[W];
        v.ovf  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return v;
    endfunction

    task automatic set_ops(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.op_a[idx*W +: W] = a;
        bus.op_b[idx*W +: W] = b;
    endtask

    task automatic wait_gnt(output int l);
        l = -1;
        for (int n = 1; n <= 3 * W && l < 0; n++) begin
            @(negedge clk);
            if (bus.gnt != 4'b0) l = n;
        end
        if (l < 0) begin
            tests++;
            fails++;
            $display("FAIL gnt_timeout: got no grant, expected one within %0d cycles", 3 * W);
        end
    endtask

    // Waits for a done strobe, checks it against the scoreboard head, drops req bits in drop.
    task automatic wait_done(input logic [3:0] drop, output int l);
        vec_t e;
        l = -1;
        for (int n = 1; n <= W + 4 && l < 0; n++) begin
            @(negedge clk);
            if (bus.done != 4'b0) begin
                l = n;
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_empty: got done=0x%0h, expected no completion", bus.done);
                end else begin
                    e = sbq.pop_front();
                    chk("done_onehot", 32'(bus.done), 32'(4'(1) << e.idx));
                    chk("sum", 32'(bus.sum), 32'(e.sum));
                    chk("cout", 32'(bus.cout), 32'(e.cout));
`ifdef SADD_ARB_OVF_EN
                    chk("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
                end
                bus.req = bus.req & ~(bus.done & drop);
            end
        end
        if (l < 0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done, expected one within %0d cycles", W + 4);
        end
    endtask

    task automatic run_one(input vec_t v);
        int l;
        set_ops(v.idx, v.a, v.b);
        bus.req = 4'(1) << v.idx;
        sbq.push_back(v);
        wait_gnt(l);
        chk("gnt_latency", 32'(l), 32'd1);
        chk("gnt_value", 32'(bus.gnt), 32'(4'(1) << v.idx));
        chk("busy_in_add", 32'(bus.busy), 32'd1);
        wait_done(4'hF, l);
        chk("done_latency", 32'(l), 32'(W));
        @(negedge clk);
        chk("busy_after_done", 32'(bus.busy), 32'd0);
        chk("gnt_after_done", 32'(bus.gnt), 32'd0);
        chk("done_one_cycle", 32'(bus.done), 32'd0);
        chk("sum_hold", 32'(bus.sum), 32'(v.sum));
    endtask

    initial begin
        vecs[0] = '{1, 8'h3C, 8'h25, 8'h61, 1'b0, 1'b0};
        vecs[1] = '{0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{3, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{2, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};

        rst_n    = 1'b0;
        bus.req  = '0;
        bus.op_a = '0;
        bus.op_b = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-requester vectors.
        for (int i = 0; i < 6; i++) run_one(vecs[i]);

        // All four requesting from reset release: grant order 0,1,2,3, W+2 apart.
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_ops(i, W'(8'h11 * (i + 1)), W'(8'hE7 - 8'h30 * i));
            sbq.push_back(mk(i, W'(8'h11 * (i + 1)), W'(8'hE7 - 8'h30 * i)));
        end
        bus.req = 4'hF;
        @(negedge clk);
        rst_n  = 1'b1;
        t_prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(lat);
            t_now = cyc;
            chk("rr_order", 32'(bus.gnt), 32'(4'(1) << i));
            if (i > 0) chk("rr_spacing", 32'(t_now - t_prev), 32'(W + 2));
            t_prev = t_now;
            wait_done(4'hF, lat);
        end
        @(negedge clk);

        // req0 held, req2 re-requests after each done: grants alternate 0,2,0,2.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_ops(0, 8'h19, 8'h2B);
        set_ops(2, 8'hC8, 8'h64);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) sbq.push_back(mk(0, 8'h19, 8'h2B));
            else            sbq.push_back(mk(2, 8'hC8, 8'h64));
        end
        bus.req = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(lat);
            chk("alt_order", 32'(bus.gnt), (i % 2 == 0) ? 32'h1 : 32'h4);
            wait_done(4'b0100, lat);
            if (i == 3) begin
                bus.req = '0;
            end else if (!bus.req[2]) begin
                @(negedge clk);
                bus.req[2] = 1'b1;
            end
        end
        @(negedge clk);

        // Reset on the 3rd ADD cycle of a grant to requester 2.
        set_ops(2, 8'h5A, 8'h33);
        bus.req = 4'b0100;
        wait_gnt(lat);
        chk("abort_gnt", 32'(bus.gnt), 32'h4);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_gnt_clr", 32'(bus.gnt), 32'd0);
        chk("abort_busy_clr", 32'(bus.busy), 32'd0);
        chk("abort_done_clr", 32'(bus.done), 32'd0);
        chk("abort_sum_clr", 32'(bus.sum), 32'd0);
        chk("abort_cout_clr", 32'(bus.cout), 32'd0);
        any_done = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            if (bus.done != 4'b0) any_done = 1'b1;
        end
        chk("abort_no_done", 32'(any_done), 32'd0);
        sbq.push_back(mk(2, 8'h5A, 8'h33));
        rst_n = 1'b1;
        wait_gnt(lat);
        chk("regrant_gnt", 32'(bus.gnt), 32'h4);
        wait_done(4'hF, lat);
        chk("regrant_latency", 32'(lat), 32'(W));
        @(negedge clk);

        // req1 dropped and op_a[1] changed on the 2nd ADD cycle.
        set_ops(1, 8'h11, 8'h22);
        bus.req = 4'b0010;
        sbq.push_back(mk(1, 8'h11, 8'h22));
        wait_gnt(lat);
        @(negedge clk);
        bus.req = '0;
        set_ops(1, 8'hEE, 8'h22);
        wait_done(4'hF, lat);
        chk("drop_done_latency", 32'(lat), 32'(W - 1));
        @(negedge clk);
        chk("drop_idle", 32'(bus.busy), 32'd0);

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sadd_rr_arbiter.md
Name: sadd_rr_arbiter

Overview:
- Time-shares one 1-bit full-adder datapath (sum = a^b^c, carry = majority) between 4 requesters.
- Each requester supplies two W-bit operands. The controller grants round-robin and adds serially, LSB first, over W cycles.
- Result is broadcast on a shared bus; completion is routed to the winner through a one-hot done strobe (demux-style).
- Sits between the requester blocks and the shared adder/mux/demux datapath.

Parameters:
W, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  4  request per requester; bit i = requester i
op_a  input  4*W  operand A; requester i at [i*W +: W]
op_b  input  4*W  operand B; requester i at [i*W +: W]
gnt  output  4  one-hot grant; all-zero when idle
busy  output  1  high while an operation is in progress (ADD or DONE)
sum  output  W  result of the most recent completed operation
cout  output  1  carry-out of the most recent completed operation
done  output  4  one-cycle completion strobe, one-hot, to the winner

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: gnt=0, busy=0, sum=0, cout=0, done=0, state=IDLE, rr pointer ptr=0, bit counter=0, carry=0.
- FSM states: IDLE, ADD, DONE.
- IDLE, no req bits set: stay in IDLE.
- IDLE, any req bit set: winner = first set bit searching ptr, ptr+1, ... mod 4. At the clock edge:
  - gnt <= one-hot(winner), busy <= 1;
  - load A/B shift registers from the winner's op_a/op_b slices;
  - carry <= 0, cnt <= 0;
  - go to ADD.
- ADD, every cycle:
  - s = A[0]^B[0]^carry;
  - carry <= (A[0]&B[0]) | (B[0]&carry) | (carry&A[0]);
  - A and B shift right by 1; s shifts into the MSB of the result register;
  - cnt <= cnt+1.
  - At cnt==W-1, transfer to DONE. ADD lasts exactly W cycles.
- DONE, exactly 1 cycle:
  - sum = result register; cout = final carry;
  - done = gnt (one-hot), gnt stays asserted;
  - next edge: gnt <= 0, busy <= 0, ptr <= winner+1 mod 4, return to IDLE.
- sum/cout update on the edge entering DONE and hold until the next DONE.
- Latency:
  - gnt rises 1 edge after req is seen in IDLE;
  - done is high W cycles after gnt rises;
  - minimum spacing between grants is W+2 cycles.
- Operands are captured only at grant. op_a/op_b changes afterwards are ignored.
- req deasserted mid-operation: ignored; the operation completes and done still pulses.
- Requester must drop req in the cycle it sees done. A req still high in the following IDLE cycle is a new request, arbitrated with the updated ptr.
- Simultaneous requests: only one winner per IDLE cycle; losers keep req high and wait.
- Reset asserted mid-operation: every output and all internal state return to reset values immediately (asynchronous). The aborted operation produces no done.
- Sum is the modulo-2^W sum; cout is bit W of the full sum.

Optional Feature:
SADD_ARB_OVF_EN
- Defined:
  - adds output port ovf (1 bit, reset 0);
  - ovf = carry into the MSB XOR cout (two's-complement signed overflow);
  - ovf is registered with sum/cout and holds until the next DONE.
- Undefined: no ovf port, no overflow logic; all other behaviour is identical.

Test Plan:
- W=8, req=0010, op_a[1]=0x3C, op_b[1]=0x25 → gnt=0010 one cycle later; done=0010 eight cycles after gnt; sum=0x61, cout=0; busy low one cycle after done.
- req=0001, 0xFF+0x01 → sum=0x00, cout=1, ovf=0. Then 0x7F+0x01 → sum=0x80, cout=0, ovf=1 (OVF_EN build).
- req=1111 held from reset release, each requester dropping req on its done → grant order 0,1,2,3; consecutive gnt rising edges 10 cycles apart; each sum matches its own operands.
- req0 held continuously, req2 toggled to re-request after each done → grants alternate 0,2,0,2; neither requester is starved.
- Assert rst_n=0 on the 3rd ADD cycle of a grant to requester 2 → gnt, busy, done, sum, cout read 0 immediately; no done pulse. After release with req2 still high: fresh grant to requester 2, correct full result.
- req1 dropped on the 2nd ADD cycle and op_a[1] changed → done[1] still pulses, and sum reflects the operands captured at grant.
